// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, FSM states, config field widths.
package led_pkg;

    typedef enum logic [1:0] {
        LED_MODE_OFF   = 2'd0,
        LED_MODE_BLINK = 2'd1,
        LED_MODE_RUN   = 2'd2,
        LED_MODE_ALT   = 2'd3
    } led_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } led_state_t;

    localparam int LED_RATE_W = 2;
    localparam int LED_RCNT_W = 3;

endpackage

// File: rtl/led_tick_gen.sv
// Shared base-tick prescaler: counts 0..TICK_CNT-1 and wraps, frozen while Hold is high.
// tick is combinational in the terminal-count cycle and is never asserted during Hold.
module led_tick_gen #(
    parameter int TICK_CNT = 25_000_000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Hold,
    output logic tick
);

    localparam int CW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CNT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (!Hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = !Hold && (cnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: OFF / BLINK / RUN / ALT patterns stepped every 2^rate base ticks.
// Optional LED_SEQ_DIM_EN adds a Cfg_duty port and 3-bit PWM dimming of the LED drive.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int TICK_CNT = 25_000_000,
    parameter int LED_NUM  = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Cfg_valid,
    output logic                  Cfg_ready,
    input  logic [1:0]            Cfg_mode,
    input  logic [LED_RATE_W-1:0] Cfg_rate,
`ifdef LED_SEQ_DIM_EN
    input  logic [2:0]            Cfg_duty,
`endif
    input  logic                  Hold,
    output logic                  Step,
    output logic [LED_NUM-1:0]    Led
);

    led_state_t            state, state_nxt;
    led_mode_t             mode_q, pmode_q;
    logic [LED_RATE_W-1:0] rate_q, prate_q;
    logic [LED_RCNT_W-1:0] rate_cnt;
    logic [LED_NUM-1:0]    pat_q, pat_nxt;
    logic                  tick, step, xfer;
    logic                  load_cfg, load_pend, apply_pend;

    function automatic logic [LED_NUM-1:0] init_pat(input led_mode_t m);
        logic [LED_NUM-1:0] p;
        p = '0;
        case (m)
            LED_MODE_RUN: p[0] = 1'b1;
            LED_MODE_ALT: for (int i = 0; i < LED_NUM; i++) p[i] = (i % 2 == 0);
            default:      p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [LED_NUM-1:0] adv_pat(input logic [LED_NUM-1:0] p, input led_mode_t m);
        if (m == LED_MODE_RUN) return {p[LED_NUM-2:0], p[LED_NUM-1]};
        return ~p;
    endfunction

    // The prescaler is parked at zero in IDLE; it always wraps to zero on the step that returns here.
    led_tick_gen #(.TICK_CNT(TICK_CNT)) u_tick (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Hold    (Hold || (state == IDLE)),
        .tick    (tick)
    );

    assign step      = tick && (rate_cnt == LED_RCNT_W'((4'd1 << rate_q) - 4'd1));
    assign Cfg_ready = (state != PEND);
    assign xfer      = Cfg_valid && Cfg_ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rate_cnt <= '0;
        end else if (state == IDLE || step) begin
            rate_cnt <= '0;
        end else if (tick) begin
            rate_cnt <= rate_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        pat_nxt    = pat_q;
        load_cfg   = 1'b0;
        load_pend  = 1'b0;
        apply_pend = 1'b0;
        case (state)
            IDLE: begin
                if (xfer && led_mode_t'(Cfg_mode) != LED_MODE_OFF) begin
                    state_nxt = RUN;
                    pat_nxt   = init_pat(led_mode_t'(Cfg_mode));
                    load_cfg  = 1'b1;
                end
            end
            RUN: begin
                // A request on a step cycle lets this step advance; the new config waits for the next one.
                if (step) pat_nxt = adv_pat(pat_q, mode_q);
                if (xfer) begin
                    state_nxt = PEND;
                    load_pend = 1'b1;
                end
            end
            PEND: begin
                if (step) begin
                    if (pmode_q == LED_MODE_OFF) begin
                        state_nxt = IDLE;
                        pat_nxt   = '0;
                    end else begin
                        state_nxt  = RUN;
                        pat_nxt    = init_pat(pmode_q);
                        apply_pend = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                pat_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            pat_q   <= '0;
            Step    <= 1'b0;
            mode_q  <= LED_MODE_OFF;
            rate_q  <= '0;
            pmode_q <= LED_MODE_OFF;
            prate_q <= '0;
        end else begin
            state <= state_nxt;
            pat_q <= pat_nxt;
            Step  <= step;
            if (load_cfg) begin
                mode_q <= led_mode_t'(Cfg_mode);
                rate_q <= Cfg_rate;
            end else if (apply_pend) begin
                mode_q <= pmode_q;
                rate_q <= prate_q;
            end
            if (load_pend) begin
                pmode_q <= led_mode_t'(Cfg_mode);
                prate_q <= Cfg_rate;
            end
        end
    end

`ifdef LED_SEQ_DIM_EN
    logic [2:0] duty_q, pduty_q, pwm_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            duty_q  <= 3'd7;
            pduty_q <= 3'd7;
            pwm_cnt <= '0;
        end else begin
            if (!Hold) pwm_cnt <= pwm_cnt + 1'b1;
            if (load_cfg) duty_q <= Cfg_duty;
            else if (apply_pend) duty_q <= pduty_q;
            if (load_pend) pduty_q <= Cfg_duty;
        end
    end

    assign Led = pat_q & {LED_NUM{pwm_cnt <= duty_q}};
`else
    assign Led = pat_q;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl (TICK_CNT=4, LED_NUM=4): directed vector table, hand sequences, random vs. model.
module tb_led_seq_ctrl;

    localparam int TICK = 4;
    localparam int N    = 4;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Cfg_valid = 1'b0;
    logic         Hold = 1'b0;
    logic [1:0]   Cfg_mode = 2'd0;
    logic [1:0]   Cfg_rate = 2'd0;
`ifdef LED_SEQ_DIM_EN
    logic [2:0]   Cfg_duty = 3'd7;
`endif
    wire          Cfg_ready;
    wire          Step;
    wire [N-1:0]  Led;

    led_seq_ctrl #(.TICK_CNT(TICK), .LED_NUM(N)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Cfg_valid (Cfg_valid),
        .Cfg_ready (Cfg_ready),
        .Cfg_mode  (Cfg_mode),
        .Cfg_rate  (Cfg_rate),
`ifdef LED_SEQ_DIM_EN
        .Cfg_duty  (Cfg_duty),
`endif
        .Hold      (Hold),
        .Step      (Step),
        .Led       (Led)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference: 0 idle, 1 running, 2 config pending; elapsed = un-held active cycles since last step/load.
    int          m_state, m_mode, m_rate, p_mode, p_rate, elapsed;
    logic [N-1:0] m_led;
    bit          m_step;

    typedef struct {
        bit          v;
        int          md;
        int          rt;
        logic [N-1:0] led;
        bit          stp;
        bit          rdy;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [N-1:0] pat_init(input int md);
        logic [N-1:0] p;
        p = '0;
        if (md == 2) p = 1;
        else if (md == 3) for (int i = 0; i < N; i += 2) p[i] = 1'b1;
        return p;
    endfunction

    function automatic logic [N-1:0] pat_adv(input logic [N-1:0] l, input int md);
        logic [N-1:0] r;
        if (md == 2) r = (l << 1) | (l >> (N - 1));
        else r = ~l;
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_mode = 0; m_rate = 0; p_mode = 0; p_rate = 0;
        elapsed = 0; m_led = '0; m_step = 0;
    endtask

    task automatic model_cycle(input bit v, input int md, input int rt, input bit h);
        bit xfer, stp;
        int period;
        xfer   = v && (m_state != 2);
        period = TICK * (1 << m_rate);
        stp    = (m_state != 0) && !h && (elapsed == period - 1);
        m_step = stp;
        case (m_state)
            0: if (xfer && md != 0) begin
                m_mode = md; m_rate = rt; m_led = pat_init(md); m_state = 1; elapsed = 0;
            end
            1: begin
                if (stp) begin m_led = pat_adv(m_led, m_mode); elapsed = 0; end
                else if (!h) elapsed++;
                if (xfer) begin p_mode = md; p_rate = rt; m_state = 2; end
            end
            default: begin
                if (stp) begin
                    elapsed = 0;
                    if (p_mode == 0) begin m_led = '0; m_state = 0; end
                    else begin
                        m_mode = p_mode; m_rate = p_rate; m_led = pat_init(p_mode); m_state = 1;
                    end
                end else if (!h) elapsed++;
            end
        endcase
    endtask

    task automatic check(input string name, input logic [N-1:0] led_e, input bit stp_e, input bit rdy_e);
        tests++;
        if (Led !== led_e || Step !== stp_e || Cfg_ready !== rdy_e) begin
            fails++;
            $display("FAIL %s @%0t: Led=%b Step=%b Cfg_ready=%b, required Led=%b Step=%b Cfg_ready=%b",
                     name, $time, Led, Step, Cfg_ready, led_e, stp_e, rdy_e);
        end
    endtask

    // Called at a negedge: apply inputs for the coming edge, advance the model, land on the next negedge.
    task automatic drive(input bit v, input int md, input int rt, input bit h);
        Cfg_valid = v;
        Cfg_mode  = 2'(md);
        Cfg_rate  = 2'(rt);
        Hold      = h;
        model_cycle(v, md, rt, h);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Cfg_valid = 0; Hold = 0;
        Reset_n = 0;
        model_reset();
        @(negedge Clk);
        Reset_n = 1;
    endtask

    function automatic void add(input bit v, input int md, input int rt,
                                input logic [N-1:0] led, input bit stp, input bit rdy, input int n = 1);
        vec_t e;
        e.v = v; e.md = md; e.rt = rt; e.led = led; e.stp = stp; e.rdy = rdy;
        for (int i = 0; i < n; i++) tbl.push_back(e);
    endfunction

    initial begin
        bit h;
        // RUN rate0, advance twice, then request ALT (pending), then OFF (pending) back to idle.
        add(0, 0, 0, 4'h0, 0, 1);
        add(1, 2, 0, 4'h1, 0, 1);
        add(0, 0, 0, 4'h1, 0, 1, 3);
        add(0, 0, 0, 4'h2, 1, 1);
        add(0, 0, 0, 4'h2, 0, 1, 3);
        add(0, 0, 0, 4'h4, 1, 1);
        add(1, 3, 0, 4'h4, 0, 0);
        add(0, 0, 0, 4'h4, 0, 0, 2);
        add(0, 0, 0, 4'h5, 1, 1);
        add(0, 0, 0, 4'h5, 0, 1, 3);
        add(0, 0, 0, 4'hA, 1, 1);
        add(1, 0, 0, 4'hA, 0, 0);
        add(0, 0, 0, 4'hA, 0, 0, 2);
        add(0, 0, 0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 0, 1);
        // Request landing on the very step cycle: current pattern advances, ALT waits a full period.
        add(1, 2, 0, 4'h1, 0, 1);
        add(0, 0, 0, 4'h1, 0, 1, 3);
        add(1, 3, 0, 4'h2, 1, 0);
        add(0, 0, 0, 4'h2, 0, 0, 3);
        add(0, 0, 0, 4'h5, 1, 1);

        model_reset();
        repeat (2) @(negedge Clk);
        check("reset", 4'h0, 0, 1);
        Reset_n = 1;

        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 0, 0);
            check("idle_quiet", 4'h0, 0, 1);
        end

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].md, tbl[i].rt, 0);
            check($sformatf("vec%0d", i), tbl[i].led, tbl[i].stp, tbl[i].rdy);
        end

        // BLINK rate 2: 16-cycle period.
        do_reset();
        drive(1, 1, 2, 0);
        check("blink_load", 4'h0, 0, 1);
        for (int i = 1; i <= 32; i++) begin
            drive(0, 0, 0, 0);
            check($sformatf("blink_c%0d", i), (i >= 16 && i < 32) ? 4'hF : 4'h0, (i == 16 || i == 32), 1);
        end

        // Hold mid-period: remaining count resumes after release.
        do_reset();
        drive(1, 2, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1);
            check("hold_frozen", 4'h1, 0, 1);
        end
        drive(0, 0, 0, 0);
        check("hold_resume1", 4'h1, 0, 1);
        drive(0, 0, 0, 0);
        check("hold_resume_step", 4'h2, 1, 1);

        // Asynchronous reset while a config is pending.
        drive(1, 3, 1, 0);
        check("pend_entered", m_led, m_step, 0);
        #2 Reset_n = 0;
        #1 check("async_reset", 4'h0, 0, 1);
        model_reset();
        @(negedge Clk);
        Reset_n = 1;

        h = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) h = !h;
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 2), h);
            check("random", m_led, m_step, m_state != 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
